// File: rtl/byteswap_mode_core.sv
// rtl/byteswap_mode_core.sv - runtime-selectable byte-reversal stream core with beat counting
// Define BYTESWAP_SKID_EN for a skid-buffered s_tready with no combinational path from m_tready.
module byteswap_mode_core #(
  parameter int C_DATA_WIDTH   = 512,
  parameter int C_LENGTH_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      ctrl_start,
  input  logic [1:0]                ctrl_mode,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  output logic                      ctrl_busy,
  output logic                      ctrl_done,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [C_DATA_WIDTH-1:0]   m_tdata,
  output logic                      m_tlast
);
  localparam int BYTES = C_DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int CW    = C_LENGTH_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state_q;
  logic [1:0]              mode_q;
  logic [CW-1:0]           beats_q;
  logic [CW-1:0]           in_cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    m_tvalid_q;
  logic                    m_tlast_q;
  logic [C_DATA_WIDTH-1:0] m_tdata_q;

  logic [CW-1:0]           beats_d;
  logic                    rem;
  logic                    last_in;
  logic                    in_fire;
  logic                    out_ready;
  logic                    out_last_fire;
  logic [C_DATA_WIDTH-1:0] swapped;

  // Reversing bytes inside a 2^k-byte lane is the same as XORing the byte index with 2^k-1.
  function automatic logic [C_DATA_WIDTH-1:0] swap_bytes(input logic [C_DATA_WIDTH-1:0] d,
                                                         input logic [1:0] m);
    logic [C_DATA_WIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < BYTES; i++) begin
      case (m)
        2'd1:    o[8*i +: 8] = d[8*(i ^ 1) +: 8];
        2'd2:    o[8*i +: 8] = d[8*(i ^ 3) +: 8];
        2'd3:    o[8*i +: 8] = d[8*(i ^ 7) +: 8];
        default: o[8*i +: 8] = d[8*i +: 8];
      endcase
    end
    return o;
  endfunction

  assign beats_d       = ({1'b0, ctrl_length} + CW'(BYTES - 1)) >> LOG2B;
  assign rem           = (in_cnt_q != beats_q);
  assign last_in       = (in_cnt_q == beats_q - CW'(1));
  assign in_fire       = s_tvalid & s_tready;
  assign out_ready     = ~m_tvalid_q | m_tready;
  assign out_last_fire = m_tvalid_q & m_tready & m_tlast_q;
  assign swapped       = swap_bytes(s_tdata, mode_q);

  assign ctrl_busy = busy_q;
  assign ctrl_done = done_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tdata   = m_tdata_q;

`ifdef BYTESWAP_SKID_EN
  logic                    skid_valid_q;
  logic                    skid_last_q;
  logic [C_DATA_WIDTH-1:0] skid_data_q;

  // Only flops feed s_tready; a beat is taken only while the skid entry is empty.
  assign s_tready = (state_q == RUN) & rem & ~skid_valid_q;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else if (out_ready) begin
      if (skid_valid_q) begin
        m_tvalid_q   <= 1'b1;
        m_tdata_q    <= skid_data_q;
        m_tlast_q    <= skid_last_q;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= swapped;
        m_tlast_q  <= last_in;
      end else begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= swapped;
      skid_last_q  <= last_in;
    end
  end
`else
  assign s_tready = (state_q == RUN) & rem & out_ready;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else if (in_fire) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= swapped;
      m_tlast_q  <= last_in;
    end else if (out_ready) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end
  end
`endif

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q  <= IDLE;
      mode_q   <= 2'd0;
      beats_q  <= '0;
      in_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_fire) begin
        in_cnt_q <= in_cnt_q + CW'(1);
      end
      case (state_q)
        IDLE: begin
          if (ctrl_start) begin
            mode_q   <= ctrl_mode;
            beats_q  <= beats_d;
            in_cnt_q <= '0;
            busy_q   <= 1'b1;
            if (beats_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (out_last_fire) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (in_fire & last_in) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_last_fire) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_byteswap_mode_core.sv
// tb/tb_byteswap_mode_core.sv - scoreboard bench for byteswap_mode_core
// A 64-bit and a 512-bit instance share stimulus; sel picks which one is driven and observed.
module tb_byteswap_mode_core;
  localparam int LW = 32;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } beat_t;

  logic          ap_clk      = 1'b0;
  logic          areset      = 1'b1;
  logic          sel         = 1'b0;
  logic          ctrl_start  = 1'b0;
  logic [1:0]    ctrl_mode   = 2'd0;
  logic [LW-1:0] ctrl_length = '0;
  logic          s_tvalid    = 1'b0;
  logic [511:0]  s_tdata     = '0;
  logic          m_tready    = 1'b1;
  logic          rand_en     = 1'b0;

  logic         busy_a, done_a, str_a, mv_a, ml_a;
  logic [63:0]  md_a;
  logic         busy_b, done_b, str_b, mv_b, ml_b;
  logic [511:0] md_b;

  byteswap_mode_core #(.C_DATA_WIDTH(64), .C_LENGTH_WIDTH(LW)) u_a (
    .ap_clk(ap_clk), .areset(areset),
    .ctrl_start(ctrl_start & ~sel), .ctrl_mode(ctrl_mode), .ctrl_length(ctrl_length),
    .ctrl_busy(busy_a), .ctrl_done(done_a),
    .s_tvalid(s_tvalid & ~sel), .s_tready(str_a), .s_tdata(s_tdata[63:0]),
    .m_tvalid(mv_a), .m_tready(m_tready), .m_tdata(md_a), .m_tlast(ml_a)
  );

  byteswap_mode_core #(.C_DATA_WIDTH(512), .C_LENGTH_WIDTH(LW)) u_b (
    .ap_clk(ap_clk), .areset(areset),
    .ctrl_start(ctrl_start & sel), .ctrl_mode(ctrl_mode), .ctrl_length(ctrl_length),
    .ctrl_busy(busy_b), .ctrl_done(done_b),
    .s_tvalid(s_tvalid & sel), .s_tready(str_b), .s_tdata(s_tdata),
    .m_tvalid(mv_b), .m_tready(m_tready), .m_tdata(md_b), .m_tlast(ml_b)
  );

  logic         busy, done, str, mv, ml;
  logic [511:0] md;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign str  = sel ? str_b  : str_a;
  assign mv   = sel ? mv_b   : mv_a;
  assign ml   = sel ? ml_b   : ml_a;
  assign md   = sel ? md_b   : {448'd0, md_a};

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  beat_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int tlast_cnt   = 0;
  int last_cyc    = -10;
  int start_cyc   = 0;

  logic [63:0] mode_exp [4] = '{64'h0011223344556677, 64'h1100332255447766,
                                64'h3322110077665544, 64'h7766554433221100};

  function automatic logic [511:0] w(input logic [63:0] x);
    return {448'd0, x};
  endfunction

  function automatic logic [511:0] r8(input logic [63:0] x);
    return {8{x}};
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      m_tready = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  always @(negedge ap_clk) begin
    beat_t e;
    if (!areset && mv && m_tready) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 512'(exp_q.size()), 512'd1);
      end else begin
        e = exp_q.pop_front();
        check("m_tdata", md, e.d);
        check("m_tlast", 512'(ml), 512'(e.l));
      end
      if (ml) begin
        tlast_cnt++;
        last_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start(input logic s, input logic [1:0] mode, input logic [LW-1:0] len);
    sel         = s;
    ctrl_mode   = mode;
    ctrl_length = len;
    ctrl_start  = 1'b1;
    tlast_cnt   = 0;
    start_cyc   = cyc;
    tick();
    ctrl_start  = 1'b0;
    ctrl_mode   = ~mode;
    ctrl_length = '1;
  endtask

  task automatic send(input logic [511:0] din, input logic [511:0] dexp, input logic lexp);
    beat_t b;
    bit ok = 1'b0;
    b.d = dexp;
    b.l = lexp;
    exp_q.push_back(b);
    s_tdata  = din;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge ap_clk);
      ok = str;
    end
    tick();
    s_tvalid = 1'b0;
    check("s_tready_seen", 512'(ok), 512'd1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    int dc = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge ap_clk);
      if (done) begin
        ok = 1'b1;
        dc = cyc;
      end
    end
    check({name, "_done"}, 512'(ok), 512'd1);
    check({name, "_done_cyc"}, 512'(dc), 512'(last_cyc + 1));
    check({name, "_tlast_cnt"}, 512'(tlast_cnt), 512'd1);
    check({name, "_drained"}, 512'(exp_q.size()), 512'd0);
    tick();
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] r;
    bit act;
    int dc;

    repeat (3) tick();
    sel = 1'b0;
    @(negedge ap_clk);
    check("rst_ctrl_a", 512'({busy, done, str, mv, ml}), 512'd0);
    check("rst_data_a", md, 512'd0);
    sel = 1'b1;
    @(negedge ap_clk);
    check("rst_ctrl_b", 512'({busy, done, str, mv, ml}), 512'd0);
    check("rst_data_b", md, 512'd0);
    tick();
    areset = 1'b0;
    tick();

    // swap32 over two beats on the 64-bit bus
    start(1'b0, 2'd2, 32'd16);
    send(w(64'h0011223344556677), w(64'h3322110077665544), 1'b0);
    send(w(64'h8899AABBCCDDEEFF), w(64'hBBAA9988FFEEDDCC), 1'b1);
    wait_done("swap32");

    for (int m = 0; m < 4; m++) begin
      start(1'b0, 2'(m), 32'd8);
      send(w(64'h0011223344556677), w(mode_exp[m]), 1'b1);
      wait_done("mode");
    end

    // zero length: done right after start, nothing accepted or emitted
    start(1'b1, 2'd3, 32'd0);
    s_tvalid = 1'b1;
    act = 1'b0;
    dc = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      act = act | mv | str;
      if (done && dc < 0) dc = cyc;
    end
    tick();
    s_tvalid = 1'b0;
    check("zero_done_cyc", 512'(dc), 512'(start_cyc + 1));
    check("zero_activity", 512'(act), 512'd0);

    // 70 bytes on the 512-bit bus is two beats; a third offered beat must stay unaccepted
    start(1'b1, 2'd2, 32'd70);
    send(r8(64'h0011223344556677), r8(64'h3322110077665544), 1'b0);
    send(r8(64'h8899AABBCCDDEEFF), r8(64'hBBAA9988FFEEDDCC), 1'b1);
    s_tdata = '1;
    s_tvalid = 1'b1;
    act = 1'b0;
    dc = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ap_clk);
      act = act | str;
      if (done && dc < 0) dc = cyc;
    end
    tick();
    s_tvalid = 1'b0;
    check("len70_extra_ready", 512'(act), 512'd0);
    check("len70_done_cyc", 512'(dc), 512'(last_cyc + 1));
    check("len70_tlast_cnt", 512'(tlast_cnt), 512'd1);
    check("len70_drained", 512'(exp_q.size()), 512'd0);

    // reset after beat 10 of 32
    start(1'b1, 2'd3, 32'd2048);
    for (int i = 0; i < 10; i++) begin
      send(r8(64'h0011223344556677), r8(64'h7766554433221100), 1'b0);
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge ap_clk);
    check("midrst_ctrl", 512'({busy, done, str, mv, ml}), 512'd0);
    check("midrst_data", md, 512'd0);
    exp_q.delete();
    tick();
    start(1'b1, 2'd1, 32'd64);
    send(r8(64'h0011223344556677), r8(64'h1100332255447766), 1'b1);
    wait_done("after_rst");

    // second start during RUN must not reload mode or length
    start(1'b0, 2'd2, 32'd24);
    send(w(64'h0011223344556677), w(64'h3322110077665544), 1'b0);
    ctrl_mode   = 2'd0;
    ctrl_length = 32'd8;
    ctrl_start  = 1'b1;
    @(negedge ap_clk);
    check("busy_in_run", 512'(busy), 512'd1);
    tick();
    ctrl_start = 1'b0;
    send(w(64'h8899AABBCCDDEEFF), w(64'hBBAA9988FFEEDDCC), 1'b0);
    send(w(64'h0011223344556677), w(64'h3322110077665544), 1'b1);
    wait_done("busy_start");

    // 256 beats with random downstream stalls
    start(1'b0, 2'd3, 32'd2048);
    rand_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = {32'(i), 32'hA5A50000 | 32'(i)};
      r = {<<8{d}};
      send(w(d), w(r), i == 255);
    end
    wait_done("backpressure");
    rand_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
